// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath select codes and the per-state Moore control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR, ST_EXEC,
        ST_ALUWB, ST_IEXEC, ST_IWB, ST_BRANCH, ST_JUMP, ST_ILLEGAL
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010, ALU_SLT = 3'b011,
        ALU_AND = 3'b100, ALU_OR  = 3'b101, ALU_XOR   = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10
    } pc_src_e;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_MEM, CLS_BRANCH, CLS_IMM, CLS_JUMP, CLS_BAD
    } op_class_e;

    typedef struct packed {
        logic    pc_write;
        logic    iord;
        logic    ir_write;
        logic    mem_write;
        logic    reg_write;
        logic    memto_reg;
        logic    reg_dst;
        logic    alu_src_a;
        src_b_e  alu_src_b;
        logic    imm_zext;
        alu_op_e alu_op;
        pc_src_e pc_src;
        logic    branch_beq;
        logic    branch_bne;
        logic    illegal;
    } ctrl_t;

    // Moore control word for a state; the opcode only matters in IEXEC/BRANCH.
    // FETCH strobes are left 0 here because they are gated by memory ready.
    function automatic ctrl_t state_ctrl(input state_e st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:  c.alu_src_b = SRCB_FOUR;
            ST_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            ST_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD:  c.iord = 1'b1;
            ST_MEMWB: begin
                c.reg_write = 1'b1;
                c.memto_reg = 1'b1;
            end
            ST_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            ST_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                case (op)
                    OP_SLTI: c.alu_op = ALU_SLT;
                    OP_ANDI: begin c.alu_op = ALU_AND; c.imm_zext = 1'b1; end
                    OP_ORI:  begin c.alu_op = ALU_OR;  c.imm_zext = 1'b1; end
                    OP_XORI: begin c.alu_op = ALU_XOR; c.imm_zext = 1'b1; end
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            ST_IWB:    c.reg_write = 1'b1;
            ST_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = ALU_SUB;
                c.pc_src     = PCSRC_ALUOUT;
                c.branch_beq = (op == OP_BEQ);
                c.branch_bne = (op == OP_BNE);
            end
            ST_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
            ST_ILLEGAL: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier feeding the DECODE dispatch.
module mc_opcode_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_e  o_class
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_class and no latch is inferred.
        o_class = CLS_BAD;
        case (i_opcode)
            OP_R:                                      o_class = CLS_RTYPE;
            OP_LW, OP_SW:                              o_class = CLS_MEM;
            OP_BEQ, OP_BNE:                            o_class = CLS_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: o_class = CLS_IMM;
            OP_J:                                      o_class = CLS_JUMP;
            default:                                   o_class = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: registered Moore control word, FETCH strobes
// gated by memory ready, all outputs forced low while reset is asserted.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [OP_W-1:0] i_opcode,
    input  logic            i_mem_ready,
    output logic            o_pc_write,
    output logic            o_iord,
    output logic            o_ir_write,
    output logic            o_mem_write,
    output logic            o_reg_write,
    output logic            o_memto_reg,
    output logic            o_reg_dst,
    output logic            o_alu_src_a,
    output logic [1:0]      o_alu_src_b,
    output logic            o_imm_zext,
    output logic [2:0]      o_alu_op,
    output logic [1:0]      o_pc_src,
    output logic            o_branch_beq,
    output logic            o_branch_bne,
    output logic            o_illegal
);

    state_e    r_state;
    ctrl_t     r_ctrl;
    state_e    w_next;
    op_class_e w_class;
    ctrl_t     w_out;
    logic      w_ready;
    logic [5:0] w_op;

    assign w_op    = i_opcode[5:0];
    assign w_ready = MEM_WAIT_EN ? i_mem_ready : 1'b1;

    mc_opcode_class u_class (
        .i_opcode (w_op),
        .o_class  (w_class)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (w_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_RTYPE:  w_next = ST_EXEC;
                    CLS_MEM:    w_next = ST_MEMADR;
                    CLS_BRANCH: w_next = ST_BRANCH;
                    CLS_IMM:    w_next = ST_IEXEC;
                    CLS_JUMP:   w_next = ST_JUMP;
                    default:    w_next = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: w_next = (w_op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (w_ready) w_next = ST_MEMWB;
            ST_MEMWR:  if (w_ready) w_next = ST_FETCH;
            ST_EXEC:   w_next = ST_ALUWB;
            ST_IEXEC:  w_next = ST_IWB;
            default:   w_next = ST_FETCH;
        endcase
    end

    // The control word is computed for the state being entered, so it is
    // already registered when that state becomes current.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (i_rst) begin
            r_state <= ST_FETCH;
            r_ctrl  <= state_ctrl(ST_FETCH, w_op);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next, w_op);
        end
    end

    always_comb begin
        w_out = i_rst ? '0 : r_ctrl;
        if (!i_rst && r_state == ST_FETCH && w_ready) begin
            w_out.pc_write = 1'b1;
            w_out.ir_write = 1'b1;
        end
    end

    assign o_pc_write   = w_out.pc_write;
    assign o_iord       = w_out.iord;
    assign o_ir_write   = w_out.ir_write;
    assign o_mem_write  = w_out.mem_write;
    assign o_reg_write  = w_out.reg_write;
    assign o_memto_reg  = w_out.memto_reg;
    assign o_reg_dst    = w_out.reg_dst;
    assign o_alu_src_a  = w_out.alu_src_a;
    assign o_alu_src_b  = w_out.alu_src_b;
    assign o_imm_zext   = w_out.imm_zext;
    assign o_alu_op     = w_out.alu_op;
    assign o_pc_src     = w_out.pc_src;
    assign o_branch_beq = w_out.branch_beq;
    assign o_branch_bne = w_out.branch_bne;
    assign o_illegal    = w_out.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: one instance honours memory ready,
// a second runs with MEM_WAIT_EN=0.
module tb_multicycle_control;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC, P_ALUWB,
        P_IEXEC, P_IWB, P_BRANCH, P_JUMP, P_ILLEGAL, P_RESET
    } ph_e;

    typedef struct packed {
        logic pc_write, iord, ir_write, mem_write, reg_write, memto_reg, reg_dst, src_a;
        logic [1:0] src_b;
        logic zext;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic beq, bne, ill;
    } ov_t;

    logic clk;
    logic rst_a, rst_b;
    logic [5:0] opcode;
    logic ready;
    logic sel;

    logic pcw_a, iord_a, irw_a, mw_a, rw_a, m2r_a, rdst_a, sa_a, zx_a, beq_a, bne_a, ill_a;
    logic [1:0] sb_a, pcs_a;
    logic [2:0] aop_a;
    logic pcw_b, iord_b, irw_b, mw_b, rw_b, m2r_b, rdst_b, sa_b, zx_b, beq_b, bne_b, ill_b;
    logic [1:0] sb_b, pcs_b;
    logic [2:0] aop_b;

    ov_t obs_a, obs_b;
    ov_t sb_q[$];
    string tag_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    multicycle_control #(.OP_W(6), .MEM_WAIT_EN(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst_a), .i_opcode(opcode), .i_mem_ready(ready),
        .o_pc_write(pcw_a), .o_iord(iord_a), .o_ir_write(irw_a), .o_mem_write(mw_a),
        .o_reg_write(rw_a), .o_memto_reg(m2r_a), .o_reg_dst(rdst_a), .o_alu_src_a(sa_a),
        .o_alu_src_b(sb_a), .o_imm_zext(zx_a), .o_alu_op(aop_a), .o_pc_src(pcs_a),
        .o_branch_beq(beq_a), .o_branch_bne(bne_a), .o_illegal(ill_a)
    );

    multicycle_control #(.OP_W(6), .MEM_WAIT_EN(1'b0)) u_dut_nw (
        .i_clk(clk), .i_rst(rst_b), .i_opcode(opcode), .i_mem_ready(ready),
        .o_pc_write(pcw_b), .o_iord(iord_b), .o_ir_write(irw_b), .o_mem_write(mw_b),
        .o_reg_write(rw_b), .o_memto_reg(m2r_b), .o_reg_dst(rdst_b), .o_alu_src_a(sa_b),
        .o_alu_src_b(sb_b), .o_imm_zext(zx_b), .o_alu_op(aop_b), .o_pc_src(pcs_b),
        .o_branch_beq(beq_b), .o_branch_bne(bne_b), .o_illegal(ill_b)
    );

    always_comb begin
        obs_a = {pcw_a, iord_a, irw_a, mw_a, rw_a, m2r_a, rdst_a, sa_a, sb_a, zx_a,
                 aop_a, pcs_a, beq_a, bne_a, ill_a};
        obs_b = {pcw_b, iord_b, irw_b, mw_b, rw_b, m2r_b, rdst_b, sa_b, sb_b, zx_b,
                 aop_b, pcs_b, beq_b, bne_b, ill_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle, written straight from the state table.
    function automatic ov_t model(input ph_e ph, input logic [5:0] op, input logic rdy);
        ov_t e;
        e = '0;
        case (ph)
            P_FETCH:  begin e.pc_write = rdy; e.ir_write = rdy; e.src_b = 2'b01; end
            P_DECODE: e.src_b = 2'b11;
            P_MEMADR: begin e.src_a = 1'b1; e.src_b = 2'b10; end
            P_MEMRD:  e.iord = 1'b1;
            P_MEMWB:  begin e.reg_write = 1'b1; e.memto_reg = 1'b1; end
            P_MEMWR:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
            P_EXEC:   begin e.src_a = 1'b1; e.alu_op = 3'b010; end
            P_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
            P_IEXEC: begin
                e.src_a = 1'b1;
                e.src_b = 2'b10;
                case (op)
                    6'b001010: e.alu_op = 3'b011;
                    6'b001100: begin e.alu_op = 3'b100; e.zext = 1'b1; end
                    6'b001101: begin e.alu_op = 3'b101; e.zext = 1'b1; end
                    6'b001110: begin e.alu_op = 3'b110; e.zext = 1'b1; end
                    default:   e.alu_op = 3'b000;
                endcase
            end
            P_IWB:    e.reg_write = 1'b1;
            P_BRANCH: begin
                e.src_a  = 1'b1;
                e.alu_op = 3'b001;
                e.pc_src = 2'b01;
                e.beq    = (op == 6'b000100);
                e.bne    = (op == 6'b000101);
            end
            P_JUMP:    begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
            P_ILLEGAL: e.ill = 1'b1;
            default:   e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input ov_t got, input ov_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, push the expectation, compare at the falling edge.
    task automatic step(input ph_e ph, input logic rdy, input string name);
        ov_t got;
        ready = rdy;
        rst_a = sel ? 1'b1 : (ph == P_RESET);
        rst_b = sel ? (ph == P_RESET) : 1'b1;
        sb_q.push_back(model(ph, opcode, sel ? 1'b1 : rdy));
        tag_q.push_back($sformatf("%s@%0d", name, cyc));
        cyc++;
        @(negedge clk);
        got = sel ? obs_b : obs_a;
        check(tag_q.pop_front(), got, sb_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_rdy();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input string name, input logic [5:0] op,
                             input int fetch_waits, input int mem_waits);
        logic hi;
        hi = sel ? 1'b0 : 1'b1;
        opcode = op;
        for (int i = 0; i < fetch_waits; i++) step(P_FETCH, 1'b0, name);
        step(P_FETCH, hi, name);
        step(P_DECODE, any_rdy(), name);
        case (op)
            6'b000000: begin step(P_EXEC, any_rdy(), name); step(P_ALUWB, any_rdy(), name); end
            6'b100011: begin
                step(P_MEMADR, any_rdy(), name);
                for (int i = 0; i < mem_waits; i++) step(P_MEMRD, 1'b0, name);
                step(P_MEMRD, hi, name);
                step(P_MEMWB, any_rdy(), name);
            end
            6'b101011: begin
                step(P_MEMADR, any_rdy(), name);
                for (int i = 0; i < mem_waits; i++) step(P_MEMWR, 1'b0, name);
                step(P_MEMWR, hi, name);
            end
            6'b000100, 6'b000101: step(P_BRANCH, any_rdy(), name);
            6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
                step(P_IEXEC, any_rdy(), name);
                step(P_IWB, any_rdy(), name);
            end
            6'b000010: step(P_JUMP, any_rdy(), name);
            default:   step(P_ILLEGAL, any_rdy(), name);
        endcase
    endtask

    initial begin
        sel    = 1'b0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        opcode = 6'b000000;
        ready  = 1'b1;

        step(P_RESET, 1'b1, "reset");
        step(P_RESET, 1'b1, "reset");

        run_instr("lw",    6'b100011, 0, 0);
        run_instr("sw",    6'b101011, 0, 3);
        run_instr("ori",   6'b001101, 0, 0);
        run_instr("bne",   6'b000101, 0, 0);
        run_instr("bad",   6'b111111, 0, 0);
        run_instr("rtype", 6'b000000, 2, 0);
        run_instr("beq",   6'b000100, 0, 0);
        run_instr("addi",  6'b001000, 1, 0);
        run_instr("slti",  6'b001010, 0, 0);
        run_instr("andi",  6'b001100, 0, 0);
        run_instr("xori",  6'b001110, 0, 0);
        run_instr("j",     6'b000010, 0, 0);
        run_instr("lw_wt", 6'b100011, 0, 2);
        run_instr("bad2",  6'b010101, 0, 0);

        // Reset during a MEMRD stall abandons the load.
        opcode = 6'b100011;
        step(P_FETCH, 1'b1, "lw_rst");
        step(P_DECODE, 1'b0, "lw_rst");
        step(P_MEMADR, 1'b0, "lw_rst");
        step(P_MEMRD, 1'b0, "lw_rst");
        step(P_MEMRD, 1'b0, "lw_rst");
        step(P_RESET, 1'b1, "lw_rst");
        run_instr("after_rst", 6'b000010, 0, 0);

        // No-wait instance: ready held low must never stall.
        sel = 1'b1;
        step(P_RESET, 1'b0, "nw_reset");
        step(P_RESET, 1'b0, "nw_reset");
        run_instr("nw_lw",    6'b100011, 0, 0);
        run_instr("nw_sw",    6'b101011, 0, 0);
        run_instr("nw_rtype", 6'b000000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
